// File: rtl/ship_move_ctrl_pkg.sv
// rtl/ship_move_ctrl_pkg.sv - shared constants and encodings for the ship movement slice
package ship_pkg;

    localparam int LEFT_LIMIT     = 0;
    localparam int RIGHT_LIMIT    = 19;
    localparam int RESET_POSITION = 5;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } state_e;

endpackage

// File: rtl/ship_move_ctrl_if.sv
// rtl/ship_move_ctrl_if.sv - control/status bundle between the move sequencer and its countdown
interface ship_move_ctrl_if #(
    parameter int CNT_W = 23
);
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             clear;
    logic             zero;

    modport master (output load, output load_value, output clear, input zero);
    modport slave  (input load, input load_value, input clear, output zero);
endinterface

// File: rtl/ship_move_timer.sv
// rtl/ship_move_timer.sv - loadable countdown that parks at zero
module ship_move_timer #(
    parameter int CNT_W = 23
) (
    input  logic           i_clk_25MHz,
    input  logic           i_reset,
    ship_move_ctrl_if.slave tmr
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clear beats load; otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (tmr.clear) begin
            cnt_d = '0;
        end else if (tmr.load) begin
            cnt_d = tmr.load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // countdown register
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmr.zero = (cnt_q == '0);

endmodule

// File: rtl/ship_move_ctrl.sv
// rtl/ship_move_ctrl.sv - typematic left/right move pulse sequencer for the player ship
module ship_move_ctrl
    import ship_pkg::*;
#(
    parameter int REPEAT_DELAY  = 6_250_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int CNT_W         = 23
) (
    input  logic       i_clk_25MHz,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_left_debounced,
    input  logic       i_right_debounced,
    input  logic [4:0] i_ship_x,
    output logic       o_move_left,
    output logic       o_move_right,
    output logic [1:0] o_dir,
    output logic       o_repeating
);

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    ship_move_ctrl_if #(.CNT_W(CNT_W)) tmr_if ();

    ship_move_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk_25MHz (i_clk_25MHz),
        .i_reset     (i_reset),
        .tmr         (tmr_if.slave)
    );

    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    logic   prev_left_q, prev_left_d;
    logic   prev_right_q, prev_right_d;
    logic   move_left_q, move_left_d;
    logic   move_right_q, move_right_d;
    logic   repeating_q, repeating_d;
    logic   pulse;

    logic   active_held;
    logic   other_held;
    logic   other_rise;
    dir_e   other_dir;

    // level/edge view of the buttons relative to the current direction
    always_comb begin
        active_held = (dir_q == DIR_LEFT) ? i_left_debounced : i_right_debounced;
        other_held  = (dir_q == DIR_LEFT) ? i_right_debounced : i_left_debounced;
        other_rise  = (dir_q == DIR_LEFT) ? (i_right_debounced & ~prev_right_q)
                                          : (i_left_debounced & ~prev_left_q);
        other_dir   = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    end

    // state register; edge detectors track the buttons even while disabled
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            state_q      <= IDLE;
            dir_q        <= DIR_NONE;
            prev_left_q  <= 1'b0;
            prev_right_q <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            repeating_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            prev_left_q  <= prev_left_d;
            prev_right_q <= prev_right_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            repeating_q  <= repeating_d;
        end
    end

    // next state: release beats opposite press, which beats repeat expiry
    always_comb begin
        state_d           = state_q;
        dir_d             = dir_q;
        pulse             = 1'b0;
        tmr_if.load       = 1'b0;
        tmr_if.load_value = DELAY_LOAD;
        tmr_if.clear      = 1'b0;
        prev_left_d       = i_left_debounced;
        prev_right_d      = i_right_debounced;
        if (!i_enable) begin
            state_d      = IDLE;
            dir_d        = DIR_NONE;
            tmr_if.clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    dir_d = DIR_NONE;
                    if (i_left_debounced ^ i_right_debounced) begin
                        dir_d       = i_left_debounced ? DIR_LEFT : DIR_RIGHT;
                        pulse       = 1'b1;
                        tmr_if.load = 1'b1;
                        state_d     = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!active_held) begin
                        if (other_held) begin
                            dir_d       = other_dir;
                            pulse       = 1'b1;
                            tmr_if.load = 1'b1;
                            state_d     = DELAY;
                        end else begin
                            dir_d        = DIR_NONE;
                            tmr_if.clear = 1'b1;
                            state_d      = IDLE;
                        end
                    end else if (other_rise) begin
                        dir_d       = other_dir;
                        pulse       = 1'b1;
                        tmr_if.load = 1'b1;
                        state_d     = DELAY;
                    end else if (tmr_if.zero) begin
                        pulse             = 1'b1;
                        tmr_if.load       = 1'b1;
                        tmr_if.load_value = PERIOD_LOAD;
                        state_d           = REPEAT;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    dir_d        = DIR_NONE;
                    tmr_if.clear = 1'b1;
                end
            endcase
        end
    end

    // outputs: steer the pulse by direction and mask it at the playfield edge
    always_comb begin
        move_left_d  = pulse && (dir_d == DIR_LEFT)  && (i_ship_x != 5'(LEFT_LIMIT));
        move_right_d = pulse && (dir_d == DIR_RIGHT) && (i_ship_x != 5'(RIGHT_LIMIT));
        repeating_d  = (state_d == REPEAT);
    end

    assign o_move_left  = move_left_q;
    assign o_move_right = move_right_q;
    assign o_dir        = dir_q;
    assign o_repeating  = repeating_q;

endmodule

// File: tb/tb_ship_move_ctrl.sv
// tb/tb_ship_move_ctrl.sv - directed self-checking bench for ship_move_ctrl
module tb_ship_move_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic       l   = 1'b0;
    logic       r   = 1'b0;
    logic [4:0] x   = 5'd10;
    logic       ml, mr, rep;
    logic [1:0] dir;

    int vectors     = 0;
    int miscompares = 0;

    always #20 clk = ~clk;

    ship_move_ctrl #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2), .CNT_W(4)) dut (
        .i_clk_25MHz       (clk),
        .i_reset           (rst),
        .i_enable          (en),
        .i_left_debounced  (l),
        .i_right_debounced (r),
        .i_ship_x          (x),
        .o_move_left       (ml),
        .o_move_right      (mr),
        .o_dir             (dir),
        .o_repeating       (rep)
    );

    ship_move_ctrl_if #(.CNT_W(4)) tif ();

    ship_move_timer #(.CNT_W(4)) u_tmr (
        .i_clk_25MHz (clk),
        .i_reset     (rst),
        .tmr         (tif.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; l = 1'b0; r = 1'b0; en = 1'b1; x = 5'd10;
        tif.load = 1'b0; tif.clear = 1'b0; tif.load_value = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; l = 1'b1; r = 1'b0; en = 1'b1;
        tif.load = 1'b0; tif.clear = 1'b0; tif.load_value = 4'd0;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({ml, mr, dir, rep} !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset c=%0d got ml=%b mr=%b dir=%b rep=%b want all 0", c, ml, mr, dir, rep);
            end
        end
        rst = 1'b0; l = 1'b0;
    endtask

    task automatic test_hold_left();
        logic e_ml;
        logic e_rep;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            l = 1'b1;
            tick();
            e_ml  = (c + 1 == 1) || (c + 1 == 5) || (c + 1 == 7) || (c + 1 == 9) || (c + 1 == 11);
            e_rep = (c + 1 >= 5);
            vectors++;
            if ({ml, mr, dir, rep} !== {e_ml, 1'b0, 2'b01, e_rep}) begin
                miscompares++;
                $display("FAIL hold_left k=%0d got ml=%b mr=%b dir=%b rep=%b want ml=%b mr=0 dir=01 rep=%b",
                         c + 1, ml, mr, dir, rep, e_ml, e_rep);
            end
        end
    endtask

    task automatic test_last_press_wins();
        logic       e_ml, e_mr, e_rep;
        logic [1:0] e_dir;
        int         k;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            r = 1'b1;
            l = (c >= 3) && (c <= 8);
            tick();
            k     = c + 1;
            e_mr  = (k == 1) || (k == 10);
            e_ml  = (k == 4) || (k == 8);
            e_dir = (k >= 4 && k <= 9) ? 2'b01 : 2'b10;
            e_rep = (k == 8) || (k == 9);
            vectors++;
            if ({ml, mr, dir, rep} !== {e_ml, e_mr, e_dir, e_rep}) begin
                miscompares++;
                $display("FAIL last_press k=%0d got ml=%b mr=%b dir=%b rep=%b want ml=%b mr=%b dir=%b rep=%b",
                         k, ml, mr, dir, rep, e_ml, e_mr, e_dir, e_rep);
            end
        end
    endtask

    task automatic test_both_pressed();
        logic       e_ml;
        logic [1:0] e_dir;
        int         k;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            l = 1'b1;
            r = (c <= 3);
            tick();
            k     = c + 1;
            e_ml  = (k == 5);
            e_dir = (k >= 5) ? 2'b01 : 2'b00;
            vectors++;
            if ({ml, mr, dir, rep} !== {e_ml, 1'b0, e_dir, 1'b0}) begin
                miscompares++;
                $display("FAIL both_pressed k=%0d got ml=%b mr=%b dir=%b rep=%b want ml=%b mr=0 dir=%b rep=0",
                         k, ml, mr, dir, rep, e_ml, e_dir);
            end
        end
    endtask

    task automatic test_limits();
        logic e_rep;
        do_reset();
        x = 5'd19;
        for (int c = 0; c < 10; c++) begin
            r = 1'b1;
            tick();
            e_rep = (c + 1 >= 5);
            vectors++;
            if ({ml, mr, dir, rep} !== {1'b0, 1'b0, 2'b10, e_rep}) begin
                miscompares++;
                $display("FAIL right_limit k=%0d got ml=%b mr=%b dir=%b rep=%b want ml=0 mr=0 dir=10 rep=%b",
                         c + 1, ml, mr, dir, rep, e_rep);
            end
        end
        do_reset();
        x = 5'd0;
        for (int c = 0; c < 10; c++) begin
            l = 1'b1;
            tick();
            e_rep = (c + 1 >= 5);
            vectors++;
            if ({ml, mr, dir, rep} !== {1'b0, 1'b0, 2'b01, e_rep}) begin
                miscompares++;
                $display("FAIL left_limit k=%0d got ml=%b mr=%b dir=%b rep=%b want ml=0 mr=0 dir=01 rep=%b",
                         c + 1, ml, mr, dir, rep, e_rep);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic       e_ml, e_rep;
        logic [1:0] e_dir;
        int         k;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            l   = 1'b1;
            rst = (c == 6);
            tick();
            k     = c + 1;
            e_ml  = (k == 1) || (k == 5) || (k == 8) || (k == 12);
            e_dir = (k == 7) ? 2'b00 : 2'b01;
            e_rep = (k == 5) || (k == 6) || (k == 12) || (k == 13);
            vectors++;
            if ({ml, mr, dir, rep} !== {e_ml, 1'b0, e_dir, e_rep}) begin
                miscompares++;
                $display("FAIL mid_reset k=%0d got ml=%b mr=%b dir=%b rep=%b want ml=%b mr=0 dir=%b rep=%b",
                         k, ml, mr, dir, rep, e_ml, e_dir, e_rep);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_enable();
        logic       e_ml;
        logic [1:0] e_dir;
        int         k;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            l  = 1'b1;
            en = !((c >= 3) && (c <= 9));
            tick();
            k     = c + 1;
            e_ml  = (k == 1) || (k == 11);
            e_dir = (k >= 4 && k <= 10) ? 2'b00 : 2'b01;
            vectors++;
            if ({ml, mr, dir, rep} !== {e_ml, 1'b0, e_dir, 1'b0}) begin
                miscompares++;
                $display("FAIL enable k=%0d got ml=%b mr=%b dir=%b rep=%b want ml=%b mr=0 dir=%b rep=0",
                         k, ml, mr, dir, rep, e_ml, e_dir);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_timer();
        logic e_zero;
        do_reset();
        vectors++;
        if (tif.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL timer_reset got zero=%b want 1", tif.zero);
        end
        tif.load = 1'b1; tif.load_value = 4'd3;
        tick();
        tif.load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            e_zero = (c >= 3);
            vectors++;
            if (tif.zero !== e_zero) begin
                miscompares++;
                $display("FAIL timer_count step=%0d got zero=%b want %b", c, tif.zero, e_zero);
            end
            tick();
        end
        tif.load = 1'b1; tif.load_value = 4'd5;
        tick();
        tif.load  = 1'b0;
        tif.clear = 1'b1;
        tick();
        tif.clear = 1'b0;
        vectors++;
        if (tif.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL timer_clear got zero=%b want 1", tif.zero);
        end
    endtask

    initial begin
        tif.load = 1'b0; tif.clear = 1'b0; tif.load_value = 4'd0;
        test_reset();
        test_hold_left();
        test_last_press_wins();
        test_both_pressed();
        test_limits();
        test_mid_reset();
        test_enable();
        test_timer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ship_move_ctrl.md
# ship_move_ctrl

Movement sequencer for the player ship. Converts the held, debounced left/right buttons into single-cycle move pulses with typematic behaviour: an immediate first step, a hold-off delay, then auto-repeat at a fixed period. It arbitrates simultaneous and overlapping presses and suppresses moves at the playfield limits. Its pulse outputs drive the ship position register's left/right inputs, so the ship steps once per pulse instead of once per clock.

## Interface

Parameters:
- REPEAT_DELAY, default 6_250_000: cycles from the first pulse to the first repeat pulse (250 ms at 25 MHz). Must be ≥ 2.
- REPEAT_PERIOD, default 2_500_000: cycles between repeat pulses (100 ms). Must be ≥ 2.
- CNT_W, default 23: countdown width. Must hold max(REPEAT_DELAY, REPEAT_PERIOD) − 1.

Ports:
- i_clk_25MHz  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_enable  in  1  game running; low forces IDLE and blocks pulses
- i_left_debounced  in  1  left button level
- i_right_debounced  in  1  right button level
- i_ship_x  in  5  current ship column, range 0..19
- o_move_left  out  1  one-cycle left-step pulse
- o_move_right  out  1  one-cycle right-step pulse
- o_dir  out  2  active direction: 00 none, 01 left, 10 right
- o_repeating  out  1  high while in REPEAT

## Operation

- Registers: state, dir, countdown cnt[CNT_W-1:0], prev_left, prev_right. A rise is level & !prev. prev_* update every cycle, including while disabled.
- States:
  - IDLE: dir = none.
  - DELAY: waiting for the first repeat.
  - REPEAT: auto-repeating.
- IDLE with i_enable high and exactly one button held:
  - set dir to that button;
  - issue a pulse;
  - load cnt = REPEAT_DELAY − 1;
  - go to DELAY.
- IDLE with both buttons held, or none: stay in IDLE and issue no pulse. This matches the ship holding position when both buttons are pressed.
- DELAY/REPEAT, cnt ≠ 0: decrement cnt.
- DELAY/REPEAT, cnt = 0: issue a pulse, load cnt = REPEAT_PERIOD − 1, go to (or stay in) REPEAT.
- Last-press-wins: in DELAY/REPEAT, a rise on the opposite button switches dir to it, issues a pulse, loads REPEAT_DELAY − 1 and goes to DELAY. This has priority over the cnt = 0 pulse in the same cycle; exactly one pulse is issued.
- Release of the active button:
  - If the other button is held, switch to it and restart as for a new press.
  - Otherwise go to IDLE, with no pulse.
  - Release has priority over cnt expiry in the same cycle.
- Limit suppression: a left pulse is masked when i_ship_x == LEFT_LIMIT (0), and a right pulse when i_ship_x == RIGHT_LIMIT (19). The FSM and cnt still advance as if the pulse had been issued.
- o_move_left and o_move_right are never high in the same cycle.
- i_enable low: next state is IDLE, dir = none, cnt = 0, no pulses. When i_enable returns high, a still-held single button starts from IDLE as a new press.
- i_reset: overrides everything, including i_enable.

## Timing

- Values after reset:
  - state = IDLE, dir = 00, cnt = 0
  - prev_left = prev_right = 0
  - o_move_left = o_move_right = 0, o_repeating = 0
- All outputs are registered.
- A button held from cycle N (with i_enable high) produces:
  - the first pulse high in cycle N+1;
  - the first repeat pulse at N+1+REPEAT_DELAY;
  - further pulses every REPEAT_PERIOD cycles.
- Each pulse is exactly 1 cycle wide.
- Release in cycle M: no pulse at M+1 or later. o_dir = 00 from M+1.
- i_ship_x is sampled in the same cycle the pulse is decided. The ship register updates one cycle after the pulse, and the limit check sees that updated value.
- Reset asserted mid-DELAY/REPEAT: outputs reach their reset values at the next edge, and no pulse follows.

## Structure

- Package ship_pkg holds:
  - LEFT_LIMIT = 0, RIGHT_LIMIT = 19, RESET_POSITION = 5;
  - the dir encoding (DIR_NONE, DIR_LEFT, DIR_RIGHT);
  - the state encoding (IDLE, DELAY, REPEAT).
- Sub-module ship_move_timer: loadable countdown with inputs load, load_value and clear, and a zero flag as output. The FSM, arbitration and limit masking stay in ship_move_ctrl.

## Test plan

Test parameters: REPEAT_DELAY = 4, REPEAT_PERIOD = 2, i_enable = 1, i_ship_x = 10 unless stated.

- Hold left from cycle 0 for 12 cycles → o_move_left high at cycles 1, 5, 7, 9, 11; o_repeating high from cycle 5; o_move_right never high.
- Hold right; press left at cycle 3 (both then held) → right pulse at 1, left pulse at 4, next left pulse at 8, o_dir = 01 from 4; release left at 9 → right pulse at 10.
- Both buttons rise in the same cycle from IDLE → no pulses, o_dir = 00; release right → left pulse on the next cycle.
- i_ship_x = 19, hold right for 10 cycles → no o_move_right pulses, o_repeating still high from cycle 5; i_ship_x = 0, hold left → no left pulses.
- Hold left; assert i_reset at cycle 6 for 1 cycle → all outputs 0 at cycle 7; with left still held, a left pulse at cycle 8, repeat at 12.
- Hold left; drop i_enable at cycle 3 → no pulses while disabled, o_dir = 00; restore i_enable at cycle 10 → left pulse at 11.
